// File: rtl/alu.sv
// alu: 32-bit execute-stage ALU with registered result and zero flag
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [4:0]  shamt,
  input  logic [3:0]  ALUctrl,
  output logic [31:0] out,
  output logic        zero
);
  logic [31:0] f;
  always_comb begin
    f = '0;
    case (ALUctrl)
      4'd0:  f = in1 & in2;
      4'd1:  f = in1 | in2;
      4'd2:  f = in1 + in2;
      4'd3:  f = in1 - in2;
      4'd4:  f = {31'b0, $signed(in1) < $signed(in2)};
      4'd5:  f = {31'b0, in1 < in2};
      4'd6:  f = ~(in1 | in2);
      4'd7:  f = in1 ^ in2;
      4'd8:  f = in2 << shamt;
      4'd9:  f = in2 >> shamt;
      4'd10: f = $signed(in2) >>> shamt;
      4'd11: f = in2 << in1[4:0];
      4'd12: f = in2 >> in1[4:0];
      default: f = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    out  <= rst ? '0 : f;
    zero <= rst ? 1'b1 : (f == '0);
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized checks of alu against an arithmetic reference model
module tb_alu;
  logic        clk = 0;
  logic        rst = 1;
  logic [31:0] in1 = 0, in2 = 0;
  logic [4:0]  shamt = 0;
  logic [3:0]  ALUctrl = 0;
  logic [31:0] out;
  logic        zero;
  int checks = 0, errors = 0;

  alu dut (.clk(clk), .rst(rst), .in1(in1), .in2(in2), .shamt(shamt), .ALUctrl(ALUctrl), .out(out), .zero(zero));

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [31:0] a, logic [31:0] b, logic [4:0] s, logic [3:0] c);
    longint unsigned ua = {32'b0, a}, ub = {32'b0, b};
    int sa = a, sb = b;
    int unsigned va = a[4:0];
    logic [31:0] r;
    case (c)
      0: return a & b;
      1: return a | b;
      2: return 32'(ua + ub);
      3: return 32'(ua - ub);
      4: return (sa < sb) ? 1 : 0;
      5: return (ua < ub) ? 1 : 0;
      6: return ~(a | b);
      7: return a ^ b;
      8: return 32'(ub * (64'd1 << s));
      9: return 32'(ub / (64'd1 << s));
      10: begin
        r = 32'(ub / (64'd1 << s));
        if (b[31] && s != 0) r = r | ~(32'hFFFF_FFFF >> s);
        return r;
      end
      11: return 32'(ub * (64'd1 << va));
      12: return 32'(ub / (64'd1 << va));
      default: return 0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] eo, input logic ez);
    checks++;
    assert (out === eo) else begin
      errors++;
      $error("FAIL %s out=%0h expected=%0h", tag, out, eo);
    end
    checks++;
    assert (zero === ez) else begin
      errors++;
      $error("FAIL %s zero=%0b expected=%0b", tag, zero, ez);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] s, input logic [3:0] c);
    in1 = a; in2 = b; shamt = s; ALUctrl = c;
    tick();
  endtask

  logic [31:0] sweep_exp [13] = '{0, 30, 30, 32'd4294967286, 1, 1, 32'd4294967265, 30, 80, 5, 5, 20480, 0};
  logic [31:0] e;

  initial begin
    in1 = 10; in2 = 20; ALUctrl = 2; rst = 1;
    tick(); chk("reset1", 0, 1);
    tick(); chk("reset2", 0, 1);
    rst = 0;
    #2 chk("reset_hold", 0, 1);
    tick(); chk("release_add", 30, 0);

    for (int i = 0; i < 13; i++) begin
      op(10, 20, 2, 4'(i));
      chk($sformatf("sweep%0d", i), sweep_exp[i], sweep_exp[i] == 0);
    end

    op(32'hFFFF_FFFF, 1, 0, 4);  chk("slt_neg", 1, 0);
    op(32'hFFFF_FFFF, 1, 0, 5);  chk("sltu_big", 0, 1);
    op(32'hFFFF_FFFF, 1, 0, 2);  chk("add_wrap", 0, 1);
    op(0, 32'h8000_0000, 31, 10); chk("sra31", 32'hFFFF_FFFF, 0);
    op(0, 32'h8000_0000, 31, 9);  chk("srl31", 1, 0);
    op(0, 1, 31, 8);              chk("sll31", 32'h8000_0000, 0);
    op(0, 32'h1234_5678, 0, 10);  chk("sra0", 32'h1234_5678, 0);
    op(32'hFFFF_FFE4, 1, 0, 11);  chk("sllv_hi_ignored", 32'h10, 0);

    for (int c = 13; c < 16; c++) begin
      op(32'hDEAD_BEEF, 32'h1234_5678, 7, 4'(c));
      chk($sformatf("reserved%0d", c), 0, 1);
    end
    op(5, 7, 0, 2); chk("pre_rst_add", 12, 0);
    rst = 1;
    op(5, 6, 0, 2); chk("rst_wins", 0, 1);
    rst = 0;

    for (int i = 0; i < 1200; i++) begin
      in1 = $urandom();
      in2 = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom();
      if ($urandom_range(0, 9) == 0) in1 = in2;
      shamt = ($urandom_range(0, 3) == 0) ? 5'(31 * $urandom_range(0, 1)) : 5'($urandom());
      ALUctrl = 4'($urandom());
      rst = ($urandom_range(0, 49) == 0);
      e = rst ? 32'd0 : model(in1, in2, shamt, ALUctrl);
      tick();
      chk($sformatf("rand%0d_op%0d", i, ALUctrl), e, e == 0);
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
